// File: rtl/sipo_frame_if.sv
// sipo_frame_if: serial-in / parallel-out bus bundle.
// master drives the serial side, slave is the deframer.
interface sipo_frame_if #(
   parameter int WIDTH = 8
) ();
   logic             clr;
   logic             shift_en;
   logic             si;
   logic             so;
   logic [WIDTH-1:0] pdata;
   logic             pvalid;
   logic             busy;
   logic             parity_err;

   modport master (
      output clr, shift_en, si,
      input  so, pdata, pvalid, busy, parity_err
   );

   modport slave (
      input  clr, shift_en, si,
      output so, pdata, pvalid, busy, parity_err
   );
endinterface

// File: rtl/sipo_frame.sv
// sipo_frame: parametrised serial-in/parallel-out deframer.
// Optional even-parity trailer bit enabled by SIPO_PARITY_EN.
module sipo_frame #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         rst,
   sipo_frame_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PARITY  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;
   logic             pvalid_q, pvalid_d;
   logic [WIDTH-1:0] shifted;
`ifdef SIPO_PARITY_EN
   logic             perr_q, perr_d;
`endif

   // State register: all flops, async active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sr_q     <= '0;
         pdata_q  <= '0;
         pvalid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         pdata_q  <= pdata_d;
         pvalid_q <= pvalid_d;
`ifdef SIPO_PARITY_EN
         perr_q   <= perr_d;
`endif
      end
   end

   // Next state: clr beats shift_en; the word is captured on its last bit.
   always_comb begin
      shifted  = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.si}
                           : {bus.si, sr_q[WIDTH-1:1]};
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      pdata_d  = pdata_q;
      pvalid_d = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_d   = perr_q;
`endif
      if (bus.clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         sr_d    = '0;
      end else if (bus.shift_en) begin
`ifdef SIPO_PARITY_EN
         if (state_q == PARITY) begin
            state_d  = IDLE;
            pdata_d  = sr_q;
            pvalid_d = 1'b1;
            perr_d   = (^sr_q) ^ bus.si;
         end else
`endif
         begin
            sr_d = shifted;
            if (cnt_q == LAST) begin
               cnt_d = '0;
`ifdef SIPO_PARITY_EN
               state_d = PARITY;
`else
               state_d  = IDLE;
               pdata_d  = shifted;
               pvalid_d = 1'b1;
`endif
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = COLLECT;
            end
         end
      end
   end

   // Outputs: all taken straight from flops.
   always_comb begin
      bus.so     = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
      bus.pdata  = pdata_q;
      bus.pvalid = pvalid_q;
      bus.busy   = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
      bus.parity_err = perr_q;
`else
      bus.parity_err = 1'b0;
`endif
   end
endmodule

// File: tb/tb_sipo_frame.sv
// tb_sipo_frame: scoreboard bench for sipo_frame.
// MSB-first and LSB-first instances share one serial stimulus.
module tb_sipo_frame;
`ifdef SIPO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      logic [7:0] d;
      logic       pe;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic shift_en = 1'b0;
   logic si = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] last_w = 8'h00;

   exp_t q_m[$];
   exp_t q_l[$];
   int   pv_cyc[$];

   sipo_frame_if #(.WIDTH(8)) bus_m ();
   sipo_frame_if #(.WIDTH(8)) bus_l ();

   assign bus_m.clr = clr;
   assign bus_m.shift_en = shift_en;
   assign bus_m.si = si;
   assign bus_l.clr = clr;
   assign bus_l.shift_en = shift_en;
   assign bus_l.si = si;

   sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
      .clk(clk), .rst(rst), .bus(bus_m)
   );
   sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
      .clk(clk), .rst(rst), .bus(bus_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every pvalid.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && bus_m.pvalid === 1'b1) begin
         pv_cyc.push_back(cyc);
         if (q_m.size() == 0) begin
            chk("unexpected_pvalid_m", 1, 0);
         end else begin
            e = q_m.pop_front();
            chk("pdata_m", {24'h0, bus_m.pdata}, {24'h0, e.d});
            chk("perr_m", {31'h0, bus_m.parity_err}, {31'h0, e.pe});
         end
      end
      if (rst === 1'b1 && bus_l.pvalid === 1'b1) begin
         if (q_l.size() == 0) begin
            chk("unexpected_pvalid_l", 1, 0);
         end else begin
            e = q_l.pop_front();
            chk("pdata_l", {24'h0, bus_l.pdata}, {24'h0, e.d});
            chk("perr_l", {31'h0, bus_l.parity_err}, {31'h0, e.pe});
         end
      end
   end

   task automatic drive(input logic en, input logic b, input logic c);
      shift_en = en;
      si = b;
      clr = c;
      @(posedge clk);
      #1;
      shift_en = 1'b0;
      clr = 1'b0;
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_so_m"}, {31'h0, bus_m.so}, 0);
      chk({tag, "_pdata_m"}, {24'h0, bus_m.pdata}, 0);
      chk({tag, "_pvalid_m"}, {31'h0, bus_m.pvalid}, 0);
      chk({tag, "_busy_m"}, {31'h0, bus_m.busy}, 0);
      chk({tag, "_perr_m"}, {31'h0, bus_m.parity_err}, 0);
      chk({tag, "_pdata_l"}, {24'h0, bus_l.pdata}, 0);
      chk({tag, "_busy_l"}, {31'h0, bus_l.busy}, 0);
   endtask

   // Sends w MSB-first on si; exp_l is the hand-computed LSB-first word.
   task automatic send_frame(input logic [7:0] w, input logic [7:0] exp_l,
                             input logic p, input bit gap, input bit tim);
      logic pe;
      pe = PAR ? ((^w) ^ p) : 1'b0;
      q_m.push_back('{d: w, pe: pe});
      q_l.push_back('{d: exp_l, pe: pe});
      for (int i = 0; i < 8; i++) begin
         chk("so_m", {31'h0, bus_m.so}, {31'h0, last_w[7-i]});
         chk("so_l", {31'h0, bus_l.so}, {31'h0, last_w[7-i]});
         drive(1'b1, w[7-i], 1'b0);
         if (tim)
            chk("busy_bit", {31'h0, bus_m.busy}, {31'h0, (i < 7) || PAR});
         if (gap) drive(1'b0, ~w[7-i], 1'b0);
      end
      if (PAR) begin
         if (tim) chk("pvalid_early", {31'h0, bus_m.pvalid}, 0);
         drive(1'b1, p, 1'b0);
      end
      if (tim) begin
         chk("pvalid_m_tim", {31'h0, bus_m.pvalid}, 1);
         chk("pvalid_l_tim", {31'h0, bus_l.pvalid}, 1);
         chk("busy_end", {31'h0, bus_m.busy}, 0);
      end
      last_w = w;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk_outs_zero("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // MSB/LSB frame with timing, busy and pvalid pulse checks.
      send_frame(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("pvalid_drop", {31'h0, bus_m.pvalid}, 0);
      chk("pdata_hold", {24'h0, bus_m.pdata}, 32'hA5);

      // so replays the previous frame during this one.
      send_frame(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // Gapped frame.
      send_frame(8'hC3, 8'hC3, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // Partial frame aborted by clr (clr wins over shift_en).
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
      chk("busy_partial", {31'h0, bus_m.busy}, 1);
      drive(1'b1, 1'b1, 1'b1);
      last_w = 8'h00;
      chk("busy_clr_m", {31'h0, bus_m.busy}, 0);
      chk("busy_clr_l", {31'h0, bus_l.busy}, 0);
      chk("pdata_clr_m", {24'h0, bus_m.pdata}, 32'hC3);
      chk("pdata_clr_l", {24'h0, bus_l.pdata}, 32'hC3);
      chk("so_clr", {31'h0, bus_m.so}, 0);
      drive(1'b0, 1'b0, 1'b0);
      send_frame(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // Back-to-back frames, no dead cycle.
      pv_cyc.delete();
      send_frame(8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("b2b_pulses", pv_cyc.size(), 2);
      if (pv_cyc.size() >= 2)
         chk("b2b_spacing", pv_cyc[1] - pv_cyc[0], PAR ? 9 : 8);

      // Asynchronous reset mid-frame, between clock edges.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk_outs_zero("midrst");
      @(posedge clk);
      #1 rst = 1'b1;
      last_w = 8'h00;
      send_frame(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
      send_frame(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
      chk("busy_parity", {31'h0, bus_m.busy}, 1);
      drive(1'b1, 1'b1, 1'b1);
      chk("busy_par_clr", {31'h0, bus_m.busy}, 0);
      chk("perr_held", {31'h0, bus_m.parity_err}, 1);
      last_w = 8'h00;
      drive(1'b0, 1'b0, 1'b0);
`endif

      drive(1'b0, 1'b0, 1'b0);
      chk("pending_m", q_m.size(), 0);
      chk("pending_l", q_l.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
